// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack sequencer driving a dual-port register file; optional circular mode via STACK_CTRL_WRAP_EN
module stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] tos_data,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
  output logic [1:0]       err_code,
  output logic [AW-1:0]    rf_re_sel_a,
  output logic [AW-1:0]    rf_re_sel_b,
  input  logic [WIDTH-1:0] rf_re_data_a,
  input  logic [WIDTH-1:0] rf_re_data_b,
  output logic [AW-1:0]    rf_wr_sel_a,
  output logic [AW-1:0]    rf_wr_sel_b,
  output logic [WIDTH-1:0] rf_wr_data_a,
  output logic [WIDTH-1:0] rf_wr_data_b,
  output logic             rf_wr_en_a,
  output logic             rf_wr_en_b
);
  typedef enum logic [1:0] {RUN, ROT2, FAULT} state_t;
  typedef enum logic [2:0] {PUSH, POP, DUP, SWAP, ADD, SUB, ROT, NOP} op_t;
`ifdef STACK_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  state_t state, state_n;
  logic [AW-1:0] top, top_n, top_p1, top_m1, top_m2;
  logic [AW:0] depth_n, need;
  logic [WIDTH-1:0] tos_n, tmp, tmp_n;
  logic [1:0] err_n;
  logic wa, wb, ovf, unf;
  assign top_p1 = top + AW'(1);
  assign top_m1 = top - AW'(1);
  assign top_m2 = top - AW'(2);
  assign cmd_ready = state == RUN;
  assign empty = depth == '0;
  assign full = depth == (AW+1)'(DEPTH);
  assign need = (cmd_op == POP || cmd_op == DUP) ? (AW+1)'(1) :
                (cmd_op == SWAP || cmd_op == ADD || cmd_op == SUB) ? (AW+1)'(2) :
                (cmd_op == ROT) ? (AW+1)'(3) : '0;
  assign ovf = (cmd_op == PUSH || cmd_op == DUP) && full && !WRAP;
  assign unf = depth < need;
  // state, pointer, depth and tos register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
      top <= AW'(DEPTH-1);
      depth <= '0;
      tos_data <= '0;
      err_code <= '0;
      tmp <= '0;
    end else begin
      state <= state_n;
      top <= top_n;
      depth <= depth_n;
      tos_data <= tos_n;
      err_code <= err_n;
      tmp <= tmp_n;
    end
  end
  // command decode: next state, read selects and register-file write sequencing
  always_comb begin
    state_n = state;
    top_n = top;
    depth_n = depth;
    tos_n = tos_data;
    err_n = err_code;
    tmp_n = tmp;
    wa = 1'b0;
    wb = 1'b0;
    rf_re_sel_a = (state == RUN && cmd_op == ROT) ? top_m2 : top;
    rf_re_sel_b = top_m1;
    rf_wr_sel_a = top;
    rf_wr_sel_b = top_m1;
    rf_wr_data_a = rf_re_data_a;
    rf_wr_data_b = rf_re_data_b;
    case (state)
      RUN: if (cmd_valid) begin
        if (ovf || unf) begin
          state_n = FAULT;
          err_n = ovf ? 2'd1 : 2'd2;
        end else begin
          case (cmd_op)
            PUSH, DUP: begin
              wa = 1'b1;
              rf_wr_sel_a = top_p1;
              rf_wr_data_a = cmd_op == PUSH ? cmd_data : rf_re_data_a;
              top_n = top_p1;
              depth_n = full ? depth : depth + (AW+1)'(1);
              tos_n = cmd_op == PUSH ? cmd_data : rf_re_data_a;
            end
            POP: begin
              top_n = top_m1;
              depth_n = depth - (AW+1)'(1);
              tos_n = depth == (AW+1)'(1) ? '0 : rf_re_data_b;
            end
            SWAP: begin
              wa = 1'b1;
              wb = 1'b1;
              rf_wr_data_a = rf_re_data_b;
              rf_wr_data_b = rf_re_data_a;
              tos_n = rf_re_data_b;
            end
            ADD, SUB: begin
              wa = 1'b1;
              rf_wr_sel_a = top_m1;
              rf_wr_data_a = cmd_op == ADD ? rf_re_data_b + rf_re_data_a : rf_re_data_b - rf_re_data_a;
              top_n = top_m1;
              depth_n = depth - (AW+1)'(1);
              tos_n = rf_wr_data_a;
            end
            ROT: begin
              wa = 1'b1;
              rf_wr_sel_a = top_m2;
              rf_wr_data_a = rf_re_data_b;
              tmp_n = rf_re_data_a;
              tos_n = rf_re_data_a;
              state_n = ROT2;
            end
            default: ;
          endcase
        end
      end
      ROT2: begin
        wa = 1'b1;
        wb = 1'b1;
        rf_wr_sel_a = top_m1;
        rf_wr_sel_b = top;
        rf_wr_data_b = tmp;
        state_n = RUN;
      end
      default: if (clear_err) begin
        err_n = '0;
        state_n = RUN;
      end
    endcase
    rf_wr_en_a = wa && reset_n;
    rf_wr_en_b = wb && reset_n;
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed scoreboard bench for stack_ctrl with a behavioural register file
module tb_stack_ctrl;
  logic clock = 1'b0;
  logic reset_n, cmd_valid, cmd_ready, clear_err, empty, full;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data, tos_data, rd_a, rd_b, wd_a, wd_b;
  logic [3:0] depth;
  logic [1:0] err_code;
  logic [2:0] rs_a, rs_b, ws_a, ws_b;
  logic we_a, we_b;
  logic [7:0] mem [8];
  int total = 0, bad = 0;
  typedef struct {logic [7:0] tos; logic [3:0] dep; logic [1:0] err;} exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  stack_ctrl dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .clear_err(clear_err), .tos_data(tos_data),
    .depth(depth), .empty(empty), .full(full), .err_code(err_code),
    .rf_re_sel_a(rs_a), .rf_re_sel_b(rs_b), .rf_re_data_a(rd_a), .rf_re_data_b(rd_b),
    .rf_wr_sel_a(ws_a), .rf_wr_sel_b(ws_b), .rf_wr_data_a(wd_a), .rf_wr_data_b(wd_b),
    .rf_wr_en_a(we_a), .rf_wr_en_b(we_b)
  );

  // register file model: combinational reads, two write ports
  always @(posedge clock) begin
    if (we_a) mem[ws_a] <= wd_a;
    if (we_b) mem[ws_b] <= wd_b;
  end
  assign rd_a = mem[rs_a];
  assign rd_b = mem[rs_b];

  // both write ports must never target the same index
  always @(negedge clock) begin
    if (we_a && we_b) begin
      total++;
      assert (ws_a !== ws_b) else begin
        bad++;
        $error("FAIL wr_collide observed=%0d expected!=%0d", ws_a, ws_b);
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic [2:0] op, logic [7:0] d, logic [7:0] et, logic [3:0] ed, logic [1:0] ee);
    exp_t e;
    q.push_back('{et, ed, ee});
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    chk({tag, "_ready"}, cmd_ready, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'd7;
    e = q.pop_front();
    chk({tag, "_tos"}, tos_data, e.tos);
    chk({tag, "_depth"}, depth, e.dep);
    chk({tag, "_err"}, err_code, e.err);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    clear_err = 1'b0;
    cmd_op = 3'd7;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    cmd_data = '0;
    do_reset();
    chk("rst_depth", depth, 0);
    chk("rst_tos", tos_data, 0);
    chk("rst_err", err_code, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", cmd_ready, 1);
    step("push11", 3'd0, 8'h11, 8'h11, 1, 0);
    step("push22", 3'd0, 8'h22, 8'h22, 2, 0);
    step("add", 3'd4, 8'h00, 8'h33, 1, 0);
    chk("add_mem0", mem[0], 8'h33);
    do_reset();
    step("push05", 3'd0, 8'h05, 8'h05, 1, 0);
    step("push07", 3'd0, 8'h07, 8'h07, 2, 0);
    step("sub", 3'd5, 8'h00, 8'hFE, 1, 0);
    do_reset();
    step("push40", 3'd0, 8'h40, 8'h40, 1, 0);
    step("dup", 3'd2, 8'h00, 8'h40, 2, 0);
    step("push41", 3'd0, 8'h41, 8'h41, 3, 0);
    step("swap", 3'd3, 8'h00, 8'h40, 3, 0);
    chk("swap_mem1", mem[1], 8'h41);
    chk("swap_mem2", mem[2], 8'h40);
    step("pop1", 3'd1, 8'h00, 8'h41, 2, 0);
    step("pop2", 3'd1, 8'h00, 8'h40, 1, 0);
    step("pop3", 3'd1, 8'h00, 8'h00, 0, 0);
    chk("pop_empty", empty, 1);
    do_reset();
    step("rpush1", 3'd0, 8'h01, 8'h01, 1, 0);
    step("rpush2", 3'd0, 8'h02, 8'h02, 2, 0);
    step("rpush3", 3'd0, 8'h03, 8'h03, 3, 0);
    step("rot", 3'd6, 8'h00, 8'h01, 3, 0);
    chk("rot2_ready", cmd_ready, 0);
    @(posedge clock);
    #1;
    chk("rot_ready_back", cmd_ready, 1);
    chk("rot_tos", tos_data, 8'h01);
    chk("rot_depth", depth, 3);
    chk("rot_mem0", mem[0], 8'h02);
    chk("rot_mem1", mem[1], 8'h03);
    chk("rot_mem2", mem[2], 8'h01);
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    #1;
    chk("unf_wen_a", we_a, 0);
    chk("unf_wen_b", we_b, 0);
    step("unf_pop", 3'd1, 8'h00, 8'h00, 0, 2);
    chk("fault_ready", cmd_ready, 0);
    chk("fault_wen", we_a | we_b, 0);
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    chk("clr_err", err_code, 0);
    chk("clr_ready", cmd_ready, 1);
    chk("clr_depth", depth, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'(16 + i);
      step("fill", 3'd0, v, v, 4'(i + 1), 0);
    end
    chk("fill_full", full, 1);
`ifdef STACK_CTRL_WRAP_EN
    step("wrap_push", 3'd0, 8'h99, 8'h99, 8, 0);
    chk("wrap_mem0", mem[0], 8'h99);
`else
    step("ovf_push", 3'd0, 8'h99, 8'h17, 8, 1);
    chk("ovf_mem0", mem[0], 8'h10);
    chk("ovf_ready", cmd_ready, 0);
`endif
    do_reset();
    step("xpush1", 3'd0, 8'h01, 8'h01, 1, 0);
    step("xpush2", 3'd0, 8'h02, 8'h02, 2, 0);
    step("xpush3", 3'd0, 8'h03, 8'h03, 3, 0);
    step("xrot", 3'd6, 8'h00, 8'h01, 3, 0);
    reset_n = 1'b0;
    #1;
    chk("xrst_wen_a", we_a, 0);
    chk("xrst_wen_b", we_b, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("xrst_ready", cmd_ready, 1);
    chk("xrst_depth", depth, 0);
    chk("xrst_tos", tos_data, 0);
    chk("xrst_wen", we_a | we_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
